xpb_lut_loadable: RTL and testbench

Runtime-loadable, multi-table successor to the fixed-constant xpb lookup blocks in the modular-squaring datapath. It holds NUM_TBL independent tables of 2^IDX_W entries, DATA_W bits each, and serves one registered lookup per table per cycle. Entry 0 of every table is hardwired to zero. Entries 1..2^IDX_W-1 are filled after reset through a narrow word-serial load port, so a modulus change needs no resynthesis.

---
 rtl/xpb_lut_loadable.sv | 159 +++++++++++++++
 tb/tb_xpb_lut_loadable.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/xpb_lut_loadable.sv
// Runtime-loadable multi-table xpb lookup: NUM_TBL tables of 2^IDX_W entries,
// filled word-serially after reset and read in parallel with a registered lookup.

module xpb_lut_lane #(
    parameter int DATA_W = 1024,
    parameter int IDX_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);
    localparam int DEPTH = 1 << IDX_W;

    // Entry 0 is never written; index 0 is short-circuited to zero on read.
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= (raddr == '0) ? '0 : mem[raddr];
    end
endmodule

module xpb_lut_loadable #(
    parameter int DATA_W  = 1024,
    parameter int IDX_W   = 5,
    parameter int NUM_TBL = 4,
    parameter int LOAD_W  = 32,
    parameter int OUT_REG = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load_start,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [LOAD_W-1:0]         load_data,
    output logic                      load_done,
    input  logic                      rd_valid,
    input  logic [NUM_TBL*IDX_W-1:0]  rd_idx,
    output logic [NUM_TBL*DATA_W-1:0] data_out,
    output logic                      data_valid
);
    localparam int DEPTH  = 1 << IDX_W;
    localparam int BEATS  = DATA_W / LOAD_W;
    localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TW     = (NUM_TBL > 1) ? $clog2(NUM_TBL) : 1;
    localparam int STAGES = 1 + OUT_REG;

    typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

    state_t            state, state_n;
    logic              armed;
    logic [BW-1:0]     beat_cnt;
    logic [IDX_W-1:0]  idx_off;   // entry address minus one, so it starts at 0
    logic [TW-1:0]     tbl_cnt;
    logic [DATA_W-1:0] asm_q, asm_nxt;
    logic              beat_fire, last_beat, last_idx, entry_wr, rd_acc;
    logic [STAGES:1]   vld_pipe;
    logic [NUM_TBL-1:0][DATA_W-1:0] lane_q;

    // Holds IDLE one extra cycle after reset release before loading opens.
    always_ff @(posedge clk) begin
        if (!rst_n) armed <= 1'b0;
        else        armed <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n    = state;
        load_ready = (state == LOAD);
        load_done  = (state == READY);
        beat_fire  = load_valid && load_ready && !load_start;
        last_beat  = (beat_cnt == BW'(BEATS - 1));
        last_idx   = (idx_off == IDX_W'(DEPTH - 2));
        entry_wr   = beat_fire && last_beat;
        rd_acc     = rd_valid && load_done;
        case (state)
            IDLE:    if (armed) state_n = LOAD;
            LOAD:    if (entry_wr && last_idx && tbl_cnt == TW'(NUM_TBL - 1)) state_n = READY;
            READY:   state_n = READY;
            default: state_n = IDLE;
        endcase
        if (load_start) state_n = LOAD;
    end

    always_comb begin
        asm_nxt = asm_q;
        asm_nxt[beat_cnt*LOAD_W +: LOAD_W] = load_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || load_start) begin
            beat_cnt <= '0;
            idx_off  <= '0;
            tbl_cnt  <= '0;
            if (!rst_n) asm_q <= '0;
        end else if (beat_fire) begin
            if (last_beat) begin
                beat_cnt <= '0;
                if (last_idx) begin
                    idx_off <= '0;
                    tbl_cnt <= (tbl_cnt == TW'(NUM_TBL - 1)) ? '0 : tbl_cnt + TW'(1);
                end else begin
                    idx_off <= idx_off + IDX_W'(1);
                end
            end else begin
                asm_q    <= asm_nxt;
                beat_cnt <= beat_cnt + BW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= rd_acc;
            for (int s = 2; s <= STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
        end
    end

    assign data_valid = vld_pipe[STAGES];

    for (genvar t = 0; t < NUM_TBL; t++) begin : g_lane
        xpb_lut_lane #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (entry_wr && (tbl_cnt == TW'(t))),
            .waddr (idx_off + IDX_W'(1)),
            .wdata (asm_nxt),
            .re    (rd_acc),
            .raddr (rd_idx[t*IDX_W +: IDX_W]),
            .rdata (lane_q[t])
        );
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [NUM_TBL-1:0][DATA_W-1:0] out_q;
        always_ff @(posedge clk) begin
            if (!rst_n)           out_q <= '0;
            else if (vld_pipe[1]) out_q <= lane_q;
        end
        assign data_out = out_q;
    end else begin : g_noreg
        assign data_out = lane_q;
    end
endmodule

// File: tb/tb_xpb_lut_loadable.sv
// Randomized bench for xpb_lut_loadable against an array-based table model.

module tb_xpb_lut_loadable;
    localparam int DW = 64, IW = 2, NT = 2, LW = 32, ORG = 1, NB = 12;

    logic            clk = 1'b0, rst_n = 1'b0;
    logic            load_start = 1'b0, load_valid = 1'b0, rd_valid = 1'b0;
    logic            load_ready, load_done, data_valid;
    logic [LW-1:0]   load_data = '0;
    logic [NT*IW-1:0] rd_idx = '0;
    logic [NT*DW-1:0] data_out;

    xpb_lut_loadable #(.DATA_W(DW), .IDX_W(IW), .NUM_TBL(NT), .LOAD_W(LW), .OUT_REG(ORG)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_valid(load_valid),
        .load_ready(load_ready), .load_data(load_data), .load_done(load_done),
        .rd_valid(rd_valid), .rd_idx(rd_idx), .data_out(data_out), .data_valid(data_valid)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    logic [DW-1:0] mdl [NT][4];
    logic [DW-1:0] nv  [NT][4];
    bit ref_done = 1'b0;
    logic [NT*DW-1:0] held = '0;

    typedef struct {bit v; logic [NT*DW-1:0] d;} exp_t;
    typedef struct {bit v; logic [NT*IW-1:0] idx;} req_t;
    exp_t eq[$];
    req_t rq[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NT*DW-1:0] lookup(input logic [NT*IW-1:0] idx);
        return {mdl[1][idx[3:2]], mdl[0][idx[1:0]]};
    endfunction

    task automatic set_vals(input bit pat);
        logic [3:0] ti;
        for (int t = 0; t < NT; t++)
            for (int i = 1; i < 4; i++) begin
                ti = {2'(t), 2'(i)};
                nv[t][i] = pat ? {16{ti}} : {$urandom, $urandom};
            end
    endtask

    // Streams the first nb beats of a load; beats go table-major, entry 1 upward, low word first.
    task automatic load_beats(input int nb);
        int e, t, i, b;
        for (int k = 0; k < nb; k++) begin
            e = k / 2; t = e / 3; i = e % 3 + 1; b = k % 2;
            load_valid = 1'b1;
            load_data  = nv[t][i][b*LW +: LW];
            chk("ld_ready", load_ready, 1);
            if (k == NB - 1) chk("ld_done_pre", load_done, 0);
            step;
            if (b == 1) mdl[t][i] = nv[t][i];
        end
        load_valid = 1'b0;
        load_data  = '0;
        if (nb == NB) begin
            ref_done = 1'b1;
            chk("ld_done", load_done, 1);
            chk("ld_ready_drop", load_ready, 0);
        end
    endtask

    task automatic rd_flush;
        int n;
        req_t r;
        exp_t e;
        bit ev;
        eq.delete();
        n = rq.size();
        for (int i = 0; i < n + 2; i++) begin
            if (rq.size() > 0) begin
                r = rq.pop_front();
                rd_valid = r.v;
                rd_idx   = r.idx;
            end else begin
                rd_valid = 1'b0;
            end
            ev = rd_valid && ref_done;
            if (ev) held = lookup(rd_idx);
            eq.push_back('{ev, held});
            step;
            if (i >= 1) begin
                e = eq.pop_front();
                chk("rd_vld", data_valid, e.v);
                chk("rd_data", data_out, e.d);
            end
        end
        rd_valid = 1'b0;
    endtask

    task automatic rd_rand(input int n);
        for (int i = 0; i < n; i++)
            rq.push_back('{($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15))});
    endtask

    initial begin
        for (int t = 0; t < NT; t++)
            for (int i = 0; i < 4; i++) mdl[t][i] = '0;

        repeat (3) step;
        chk("rst_ready", load_ready, 0);
        chk("rst_done", load_done, 0);
        chk("rst_dvld", data_valid, 0);
        chk("rst_dout", data_out, 0);
        rst_n = 1'b1;
        chk("rdy_c0", load_ready, 0);
        step;
        chk("rdy_c1", load_ready, 0);
        step;
        chk("rdy_c2", load_ready, 1);
        chk("done_c2", load_done, 0);

        set_vals(1'b1);
        load_beats(NB);

        rq.push_back('{1'b1, 4'b1100});
        rq.push_back('{1'b1, 4'b0001});
        rq.push_back('{1'b1, 4'b0010});
        rq.push_back('{1'b1, 4'b0011});
        rd_flush;
        rd_rand(24);
        rd_flush;

        // Reload, interrupted by load_start on beat 5
        set_vals(1'b0);
        load_start = 1'b1; ref_done = 1'b0;
        step;
        load_start = 1'b0;
        chk("reld_ready", load_ready, 1);
        chk("reld_done", load_done, 0);
        load_beats(4);
        load_valid = 1'b1; load_data = $urandom; load_start = 1'b1;
        step;
        load_valid = 1'b0; load_start = 1'b0;
        chk("ls_ready", load_ready, 1);
        chk("ls_done", load_done, 0);
        rd_rand(6);
        rq.push_back('{1'b1, 4'b0101});
        rd_flush;
        set_vals(1'b0);
        load_beats(NB);
        rd_rand(24);
        rd_flush;

        // Reset with a read in flight
        rd_valid = 1'b1; rd_idx = 4'b0110;
        step;
        rd_valid = 1'b0; rst_n = 1'b0;
        step;
        held = '0; ref_done = 1'b0;
        chk("inflt_dvld", data_valid, 0);
        chk("inflt_dout", data_out, 0);
        chk("inflt_done", load_done, 0);
        rst_n = 1'b1;
        step;
        step;
        chk("rdy_again", load_ready, 1);

        // Reset after beat 7 of a load
        set_vals(1'b0);
        load_beats(7);
        rst_n = 1'b0;
        step;
        chk("mid_rst_done", load_done, 0);
        chk("mid_rst_dvld", data_valid, 0);
        chk("mid_rst_ready", load_ready, 0);
        rst_n = 1'b1;
        step;
        step;
        chk("rdy_post_rst", load_ready, 1);
        rq.push_back('{1'b1, 4'b1111});
        rd_rand(6);
        rd_flush;
        set_vals(1'b0);
        load_beats(NB);
        rd_rand(24);
        rd_flush;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
